// File: rtl/medidor_distancia_bcd.sv
`default_nettype none
// ============================================================================
// medidor_distancia_bcd: ultrasonic ranger, echo width -> 3-digit BCD cm
// Revision: 1.0
// ============================================================================
module medidor_distancia_bcd #(
    parameter int CICLOS_CM      = 2941,
    parameter int TRIGGER_CICLOS = 500,
    parameter int TIMEOUT_CICLOS = 1500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [2:0]  db_estado
);

    localparam int TICK_W = $clog2(CICLOS_CM);
    localparam int TRIG_W = $clog2(TRIGGER_CICLOS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CICLOS + 1);

    localparam logic [TICK_W-1:0] c_TICK_MAX  = TICK_W'(CICLOS_CM - 1);
    localparam logic [TICK_W-1:0] c_TICK_HALF = TICK_W'(CICLOS_CM / 2);
    localparam logic [TRIG_W-1:0] c_TRIG_MAX  = TRIG_W'(TRIGGER_CICLOS - 1);
    localparam logic [TO_W-1:0]   c_TO_MAX    = TO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [11:0]       c_BCD_MAX   = 12'h999;

    typedef enum logic [2:0] {
        INICIAL       = 3'd0,
        PREPARA       = 3'd1,
        ENVIA_TRIGGER = 3'd2,
        ESPERA_ECHO   = 3'd3,
        MEDINDO       = 3'd4,
        ARMAZENA      = 3'd5,
        FINAL         = 3'd6
    } estado_t;

    estado_t           r_estado;
    logic              r_echo_m;
    logic              r_echo_s;
    logic [TICK_W-1:0] r_tick;
    logic [TRIG_W-1:0] r_trig_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [11:0]       r_bcd;
    logic              r_abort;

    logic w_tick_wrap;
    logic w_to_fim;

    assign w_tick_wrap = (r_tick == c_TICK_MAX);
    assign w_to_fim    = (r_to_cnt == c_TO_MAX);
    assign db_estado   = r_estado;

    // Decimal increment with ripple carry; pinned at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != c_BCD_MAX) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= INICIAL;
            r_echo_m   <= 1'b0;
            r_echo_s   <= 1'b0;
            r_tick     <= '0;
            r_trig_cnt <= '0;
            r_to_cnt   <= '0;
            r_bcd      <= 12'h000;
            r_abort    <= 1'b0;
            trigger    <= 1'b0;
            medida     <= 12'h000;
            pronto     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            case (r_estado)
                INICIAL: begin
                    if (medir) r_estado <= PREPARA;
                end
                PREPARA: begin
                    r_tick     <= '0;
                    r_trig_cnt <= '0;
                    r_to_cnt   <= '0;
                    r_bcd      <= 12'h000;
                    r_abort    <= 1'b0;
                    timeout    <= 1'b0;
                    trigger    <= 1'b1;
                    r_estado   <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    if (r_trig_cnt == c_TRIG_MAX) begin
                        trigger  <= 1'b0;
                        r_estado <= ESPERA_ECHO;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                end
                // The rising sample of echo_s is already a high cycle, so it
                // is counted here to make the total equal the pulse width.
                ESPERA_ECHO: begin
                    if (w_to_fim) begin
                        r_abort  <= 1'b1;
                        timeout  <= 1'b1;
                        r_estado <= ARMAZENA;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_echo_s) begin
                            if (w_tick_wrap) begin
                                r_tick <= '0;
                                r_bcd  <= bcd_inc(r_bcd);
                            end else begin
                                r_tick <= r_tick + 1'b1;
                            end
                            r_estado <= MEDINDO;
                        end
                    end
                end
                MEDINDO: begin
                    if (w_to_fim) begin
                        r_abort  <= 1'b1;
                        timeout  <= 1'b1;
                        r_estado <= ARMAZENA;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_echo_s) begin
                            if (w_tick_wrap) begin
                                r_tick <= '0;
                                r_bcd  <= bcd_inc(r_bcd);
                            end else begin
                                r_tick <= r_tick + 1'b1;
                            end
                        end else begin
                            r_estado <= ARMAZENA;
                        end
                    end
                end
                ARMAZENA: begin
                    if (r_abort)
                        medida <= c_BCD_MAX;
                    else if (r_tick >= c_TICK_HALF)
                        medida <= bcd_inc(r_bcd);
                    else
                        medida <= r_bcd;
                    pronto   <= 1'b1;
                    r_estado <= FINAL;
                end
                FINAL: begin
                    pronto   <= 1'b0;
                    r_estado <= INICIAL;
                end
                default: begin
                    trigger  <= 1'b0;
                    pronto   <= 1'b0;
                    r_estado <= INICIAL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_medidor_distancia_bcd.sv
`default_nettype none
// Bench for medidor_distancia_bcd: directed and random echo widths against
// a centimetre/rounding reference model.
module tb_medidor_distancia_bcd;

    localparam int CM   = 10;
    localparam int TRIG = 5;
    localparam int TO   = 2000;
    localparam int TO_S = 20000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        medir = 1'b0;
    logic        echo = 1'b0;
    logic        trigger, pronto, timeout;
    logic [11:0] medida;
    logic [2:0]  db_estado;
    logic        s_trigger, s_pronto, s_timeout;
    logic [11:0] s_medida;
    logic [2:0]  s_db_estado;

    int n_checks = 0;
    int n_errors = 0;
    int n_pronto = 0;
    int n_trig_rise = 0;
    logic trig_prev = 1'b0;

    medidor_distancia_bcd #(.CICLOS_CM(CM), .TRIGGER_CICLOS(TRIG), .TIMEOUT_CICLOS(TO)) dut (
        .clk(clk), .reset_n(reset_n), .medir(medir), .echo(echo),
        .trigger(trigger), .medida(medida), .pronto(pronto),
        .timeout(timeout), .db_estado(db_estado)
    );

    medidor_distancia_bcd #(.CICLOS_CM(CM), .TRIGGER_CICLOS(TRIG), .TIMEOUT_CICLOS(TO_S)) u_sat (
        .clk(clk), .reset_n(reset_n), .medir(medir), .echo(echo),
        .trigger(s_trigger), .medida(s_medida), .pronto(s_pronto),
        .timeout(s_timeout), .db_estado(s_db_estado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pronto) n_pronto = n_pronto + 1;
        if (trigger && !trig_prev) n_trig_rise = n_trig_rise + 1;
        trig_prev = trigger;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: round echo width to nearest cm (half up), clamp, encode BCD.
    function automatic logic [11:0] model(input int width);
        int cm;
        cm = width / CM;
        if ((width % CM) >= CM / 2) cm++;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    // From the cycle trigger is seen high: measure its width, then return.
    task automatic trigger_phase(input string tag);
        int guard, len;
        guard = 0;
        while (!trigger && guard < 20) begin @(negedge clk); guard++; end
        check({tag, "_trig_seen"}, 32'(trigger), 32'd1);
        check({tag, "_to_cleared"}, 32'(timeout), 32'd0);
        len = 0;
        while (trigger && len < 100) begin len++; @(negedge clk); end
        check({tag, "_trig_len"}, 32'(len), 32'(TRIG));
    endtask

    task automatic echo_phase(input int wait_c, input int width, input bit poke);
        repeat (wait_c) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            medir = poke && (i == width / 2);
        end
        medir = 1'b0;
        echo = 1'b0;
    endtask

    task automatic wait_pronto(input string tag, input int bound);
        int guard;
        guard = 0;
        while (!pronto && guard < bound) begin @(negedge clk); guard++; end
        check({tag, "_pronto_seen"}, 32'(pronto), 32'd1);
    endtask

    task automatic measure(input string tag, input int wait_c, input int width, input bit poke);
        int p0;
        p0 = n_pronto;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        trigger_phase(tag);
        echo_phase(wait_c, width, poke);
        wait_pronto(tag, 200);
        check({tag, "_medida"}, 32'(medida), 32'(model(width)));
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        check({tag, "_pronto_count"}, 32'(n_pronto - p0), 32'd1);
        check({tag, "_medida_hold"}, 32'(medida), 32'(model(width)));
    endtask

    initial begin
        int k, p0, t0, w, d;

        repeat (3) @(negedge clk);
        #1;
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_medida", 32'(medida), 32'h000);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        measure("nominal", 20, 125, 1'b0);
        measure("w124", 20, 124, 1'b0);
        measure("w9", 7, 9, 1'b0);
        measure("w4", 3, 4, 1'b0);
        measure("w995", 0, 995, 1'b0);
        measure("w1994", 2, 1994, 1'b0);

        for (int r = 0; r < 6; r++) begin
            w = $urandom_range(1, 1900);
            d = $urandom_range(0, 50);
            measure($sformatf("rand%0d", r), d, w, 1'b0);
        end

        // Asynchronous reset while in MEDINDO
        p0 = n_pronto;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        trigger_phase("mid_rst");
        echo = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_rst_in_medindo", 32'(db_estado), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_trigger", 32'(trigger), 32'd0);
        check("mid_rst_medida", 32'(medida), 32'h000);
        check("mid_rst_pronto", 32'(pronto), 32'd0);
        check("mid_rst_estado", 32'(db_estado), 32'd0);
        @(negedge clk) begin echo = 1'b0; reset_n = 1'b1; end
        repeat (40) @(negedge clk);
        #1;
        check("mid_rst_no_pronto", 32'(n_pronto - p0), 32'd0);

        // Echo never arrives
        p0 = n_pronto;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        trigger_phase("tmo");
        k = 0;
        while (!pronto && k < 3000) begin @(negedge clk); k++; end
        check("tmo_pronto_seen", 32'(pronto), 32'd1);
        check("tmo_delay_ge", 32'(k >= TO && k < TO + 10), 32'd1);
        check("tmo_medida", 32'(medida), 32'h999);
        check("tmo_flag", 32'(timeout), 32'd1);
        repeat (4) @(negedge clk);
        check("tmo_flag_sticky", 32'(timeout), 32'd1);
        measure("after_tmo", 10, 50, 1'b0);

        // medir during MEDINDO is ignored
        t0 = n_trig_rise;
        measure("poke", 20, 125, 1'b1);
        check("poke_one_trigger", 32'(n_trig_rise - t0), 32'd1);

        // medir held high: back-to-back measurements
        p0 = n_pronto;
        t0 = n_trig_rise;
        @(negedge clk) medir = 1'b1;
        trigger_phase("held1");
        echo_phase(5, 30, 1'b0);
        medir = 1'b1;
        wait_pronto("held1", 200);
        check("held1_medida", 32'(medida), 32'(model(30)));
        @(negedge clk);
        trigger_phase("held2");
        medir = 1'b0;
        echo_phase(5, 47, 1'b0);
        wait_pronto("held2", 200);
        check("held2_medida", 32'(medida), 32'(model(47)));
        repeat (6) @(negedge clk);
        #1;
        check("held_triggers", 32'(n_trig_rise - t0), 32'd2);
        check("held_prontos", 32'(n_pronto - p0), 32'd2);

        // Saturation on the long-timeout instance; the short one aborts
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) medir = 1'b1;
        @(negedge clk) medir = 1'b0;
        trigger_phase("sat");
        echo_phase(2, 9995, 1'b0);
        k = 0;
        while (!s_pronto && k < 200) begin @(negedge clk); k++; end
        check("sat_pronto_seen", 32'(s_pronto), 32'd1);
        check("sat_medida", 32'(s_medida), 32'(model(9995)));
        check("sat_medida_999", 32'(s_medida), 32'h999);
        check("sat_timeout", 32'(s_timeout), 32'd0);
        check("sat_short_tmo_medida", 32'(medida), 32'h999);
        check("sat_short_tmo_flag", 32'(timeout), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
